// File: rtl/reg_op_sequencer_pkg.sv
// Shared opcodes, FSM encoding and widths for the register-file micro-op path.
// Decode uses the same op_e values.
package reg_op_sequencer_pkg;
  localparam int REG_W  = 4;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_LD  = 3'd1,
    OP_XCH = 3'd2,
    OP_INC = 3'd3,
    OP_ISZ = 3'd4,
    OP_FIM = 3'd5,
    OP_SRC = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  function automatic logic is_pair_op(op_e op);
    return (op == OP_FIM) || (op == OP_SRC);
  endfunction
endpackage

// File: rtl/reg_op_sequencer_if.sv
// Command/response handshake plus register-file port bundle.
// master = sequencer side, slave = execute stage plus register file.
interface reg_op_sequencer_if;
  import reg_op_sequencer_pkg::*;

  logic                cmdValid;
  logic                cmdReady;
  logic [2:0]          cmdOp;
  logic [ADDR_W-1:0]   cmdAddr;
  logic [REG_W-1:0]    cmdAcc;
  logic [2*REG_W-1:0]  cmdImm;

  logic                rspValid;
  logic                rspReady;
  logic [2*REG_W-1:0]  rspData;
  logic                rspZero;
  logic                rspErr;

  logic                rfRegWe;
  logic [ADDR_W-1:0]   rfRegAddr;
  logic [REG_W-1:0]    rfRegDin;
  logic                rfPairWe;
  logic [ADDR_W-1:0]   rfPairAddr;
  logic [2*REG_W-1:0]  rfPairDin;
  logic [REG_W-1:0]    rfRegDout;
  logic [2*REG_W-1:0]  rfPairDout;

  modport master (
    input  cmdValid, cmdOp, cmdAddr, cmdAcc, cmdImm, rspReady, rfRegDout, rfPairDout,
    output cmdReady, rspValid, rspData, rspZero, rspErr,
           rfRegWe, rfRegAddr, rfRegDin, rfPairWe, rfPairAddr, rfPairDin
  );

  modport slave (
    output cmdValid, cmdOp, cmdAddr, cmdAcc, cmdImm, rspReady, rfRegDout, rfPairDout,
    input  cmdReady, rspValid, rspData, rspZero, rspErr,
           rfRegWe, rfRegAddr, rfRegDin, rfPairWe, rfPairAddr, rfPairDin
  );
endinterface

// File: rtl/reg_op_sequencer.sv
// Runs LD/XCH/INC/ISZ/FIM/SRC against the 4-bit x16 register file as
// IDLE -> [READ] -> [WRITE] -> RESP sequences, one command in flight.
module reg_op_sequencer #(
  parameter int REG_W  = reg_op_sequencer_pkg::REG_W,
  parameter int ADDR_W = reg_op_sequencer_pkg::ADDR_W
) (
  input logic                 clk,
  input logic                 rst,
  reg_op_sequencer_if.master  bus
);
  import reg_op_sequencer_pkg::*;

  if (REG_W != 4 || ADDR_W != 4) begin : g_width_check
    $error("reg_op_sequencer: REG_W and ADDR_W are fixed at 4 by the ISA");
  end

  state_e              state, state_nxt;
  op_e                 op, cmd_op;
  logic [REG_W-1:0]    acc;
  logic                accept;
  logic [REG_W-1:0]    inc_val;
  logic                reg_we, pair_we;
  logic [ADDR_W-1:0]   reg_addr, pair_addr;
  logic [REG_W-1:0]    reg_din;
  logic [2*REG_W-1:0]  pair_din, rsp_data;
  logic                rsp_zero, rsp_err;

  assign cmd_op  = op_e'(bus.cmdOp);
  assign accept  = bus.cmdValid && (state == IDLE);
  assign inc_val = bus.rfRegDout + REG_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) begin
        case (cmd_op)
          OP_LD, OP_XCH, OP_INC, OP_ISZ, OP_SRC: state_nxt = READ;
          OP_FIM:                                state_nxt = WRITE;
          default:                               state_nxt = RESP;
        endcase
      end
      READ:    state_nxt = (op == OP_XCH || op == OP_INC || op == OP_ISZ) ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    if (bus.rspReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are single-cycle pulses covering exactly the WRITE state.
  always_ff @(posedge clk) begin
    if (rst) begin
      op        <= OP_NOP;
      acc       <= '0;
      reg_we    <= 1'b0;
      pair_we   <= 1'b0;
      reg_addr  <= '0;
      pair_addr <= '0;
      reg_din   <= '0;
      pair_din  <= '0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      reg_we  <= 1'b0;
      pair_we <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          op       <= cmd_op;
          acc      <= bus.cmdAcc;
          rsp_data <= '0;
          rsp_zero <= 1'b0;
          rsp_err  <= (cmd_op == OP_RSV) || (is_pair_op(cmd_op) && bus.cmdAddr[0]);
          if (is_pair_op(cmd_op))
            pair_addr <= {bus.cmdAddr[ADDR_W-1:1], 1'b0};
          else if (cmd_op != OP_NOP && cmd_op != OP_RSV)
            reg_addr <= bus.cmdAddr;
          if (cmd_op == OP_FIM) begin
            pair_din <= bus.cmdImm;
            pair_we  <= 1'b1;
          end
        end
        READ: begin
          case (op)
            OP_LD:  rsp_data <= {{REG_W{1'b0}}, bus.rfRegDout};
            OP_SRC: rsp_data <= bus.rfPairDout;
            OP_XCH: begin
              rsp_data <= {{REG_W{1'b0}}, bus.rfRegDout};
              reg_din  <= acc;
              reg_we   <= 1'b1;
            end
            OP_INC, OP_ISZ: begin
              rsp_data <= {{REG_W{1'b0}}, inc_val};
              rsp_zero <= (inc_val == '0);
              reg_din  <= inc_val;
              reg_we   <= 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Gating with rst keeps a reset that lands on WRITE from committing the write.
  assign bus.rfRegWe    = reg_we  && !rst;
  assign bus.rfPairWe   = pair_we && !rst;
  assign bus.rfRegAddr  = reg_addr;
  assign bus.rfRegDin   = reg_din;
  assign bus.rfPairAddr = pair_addr;
  assign bus.rfPairDin  = pair_din;
  assign bus.cmdReady   = (state == IDLE);
  assign bus.rspValid   = (state == RESP);
  assign bus.rspData    = rsp_data;
  assign bus.rspZero    = rsp_zero;
  assign bus.rspErr     = rsp_err;

  a_one_strobe: assert property (@(posedge clk) !(bus.rfRegWe && bus.rfPairWe));
endmodule

// File: tb/tb_reg_op_sequencer.sv
// Scoreboard bench: a behavioural register file answers the DUT, an independent
// shadow model predicts responses and register contents.
module tb_reg_op_sequencer;
  import reg_op_sequencer_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       zero;
    logic       err;
    int         lat;
    int         regw;
    int         pairw;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_op_sequencer_if bus();
  reg_op_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  logic [3:0] rf     [16] = '{default: 4'h0};
  logic [3:0] ref_rf [16] = '{default: 4'h0};
  logic       pre_we   = 1'b0;
  logic [3:0] pre_addr = 4'h0;
  logic [3:0] pre_val  = 4'h0;

  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_val;
    if (bus.rfRegWe) rf[bus.rfRegAddr] <= bus.rfRegDin;
    if (bus.rfPairWe) begin
      rf[{bus.rfPairAddr[3:1], 1'b0}] <= bus.rfPairDin[7:4];
      rf[{bus.rfPairAddr[3:1], 1'b1}] <= bus.rfPairDin[3:0];
    end
  end
  assign bus.rfRegDout  = rf[bus.rfRegAddr];
  assign bus.rfPairDout = {rf[{bus.rfPairAddr[3:1], 1'b0}], rf[{bus.rfPairAddr[3:1], 1'b1}]};

  int         reg_we_n  = 0;
  int         pair_we_n = 0;
  logic [3:0] last_pa   = 4'h0;
  logic [7:0] last_pd   = 8'h0;
  always @(negedge clk) begin
    if (bus.rfRegWe) reg_we_n++;
    if (bus.rfPairWe) begin
      pair_we_n++;
      last_pa = bus.rfPairAddr;
      last_pd = bus.rfPairDin;
    end
  end

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dut_img();
    logic [63:0] v;
    for (int i = 0; i < 16; i++) v[i*4 +: 4] = rf[i];
    return v;
  endfunction

  function automatic logic [63:0] ref_img();
    logic [63:0] v;
    for (int i = 0; i < 16; i++) v[i*4 +: 4] = ref_rf[i];
    return v;
  endfunction

  function automatic logic [33:0] out_vec();
    return {bus.cmdReady, bus.rspValid, bus.rspData, bus.rspZero, bus.rspErr,
            bus.rfRegWe, bus.rfPairWe, bus.rfRegAddr, bus.rfPairAddr,
            bus.rfRegDin, bus.rfPairDin};
  endfunction

  task automatic model(input op_e op, input logic [3:0] a, input logic [3:0] acc,
                       input logic [7:0] imm, output exp_t e);
    logic [3:0] ev, od, n;
    ev = {a[3:1], 1'b0};
    od = {a[3:1], 1'b1};
    e = '{data: 8'h00, zero: 1'b0, err: 1'b0, lat: 1, regw: 0, pairw: 0};
    case (op)
      OP_LD:  begin e.data = {4'h0, ref_rf[a]}; e.lat = 2; end
      OP_XCH: begin e.data = {4'h0, ref_rf[a]}; ref_rf[a] = acc; e.lat = 3; e.regw = 1; end
      OP_INC, OP_ISZ: begin
        n = ref_rf[a] + 4'h1;
        e.data = {4'h0, n}; e.zero = (n == 4'h0);
        ref_rf[a] = n; e.lat = 3; e.regw = 1;
      end
      OP_FIM: begin
        ref_rf[ev] = imm[7:4]; ref_rf[od] = imm[3:0];
        e.err = a[0]; e.lat = 2; e.pairw = 1;
      end
      OP_SRC: begin e.data = {ref_rf[ev], ref_rf[od]}; e.err = a[0]; e.lat = 2; end
      OP_RSV: e.err = 1'b1;
      default: ;
    endcase
  endtask

  task automatic preload(input logic [3:0] a, input logic [3:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_val = v;
    ref_rf[a] = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Returns at a negedge with the DUT back in IDLE.
  task automatic run_cmd(input op_e op, input logic [3:0] a, input logic [3:0] acc,
                         input logic [7:0] imm, input int hold);
    exp_t e, got_e;
    int n, rw0, pw0;
    logic [7:0] d0;
    model(op, a, acc, imm, e);
    sb.push_back(e);
    n = 0;
    while (!bus.cmdReady && n < 20) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", bus.cmdReady, 1'b1);
    rw0 = reg_we_n; pw0 = pair_we_n;
    bus.cmdValid = 1'b1; bus.cmdOp = op; bus.cmdAddr = a; bus.cmdAcc = acc; bus.cmdImm = imm;
    @(posedge clk);
    @(negedge clk);
    bus.cmdValid = 1'b0;
    n = 1;
    while (!bus.rspValid && n < 10) begin @(negedge clk); n++; end
    chk("rsp_valid_wait", bus.rspValid, 1'b1);
    got_e = sb.pop_front();
    chk($sformatf("latency op%0d", op), n, got_e.lat);
    chk($sformatf("rsp_data op%0d", op), bus.rspData, got_e.data);
    chk($sformatf("rsp_zero op%0d", op), bus.rspZero, got_e.zero);
    chk($sformatf("rsp_err op%0d", op), bus.rspErr, got_e.err);
    if (op == OP_SRC) chk("src_pair_addr", bus.rfPairAddr, {a[3:1], 1'b0});
    d0 = bus.rspData;
    if (hold > 0) begin
      bus.rspReady = 1'b0;
      bus.cmdValid = 1'b1; bus.cmdOp = OP_LD; bus.cmdAddr = 4'h0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid", bus.rspValid, 1'b1);
        chk("hold_data", bus.rspData, d0);
        chk("hold_cmd_ready", bus.cmdReady, 1'b0);
      end
    end
    bus.rspReady = 1'b1;
    @(negedge clk);
    if (hold > 0) begin
      chk("ready_after_hs", bus.cmdReady, 1'b1);
      bus.cmdValid = 1'b0;
    end
    chk("rsp_valid_drop", bus.rspValid, 1'b0);
    chk($sformatf("reg_strobes op%0d", op), reg_we_n - rw0, got_e.regw);
    chk($sformatf("pair_strobes op%0d", op), pair_we_n - pw0, got_e.pairw);
    if (op == OP_FIM) chk("fim_pair_bus", {last_pa, last_pd}, {a[3:1], 1'b0, imm});
    chk($sformatf("rf_image op%0d", op), dut_img(), ref_img());
  endtask

  task automatic reset_during_inc(input logic [3:0] a);
    int n;
    n = 0;
    while (!bus.cmdReady && n < 20) begin @(negedge clk); n++; end
    bus.cmdValid = 1'b1; bus.cmdOp = OP_INC; bus.cmdAddr = a; bus.cmdAcc = 4'h0; bus.cmdImm = 8'h0;
    @(posedge clk);
    @(negedge clk);
    bus.cmdValid = 1'b0;
    n = 0;
    while (!bus.rfRegWe && n < 10) begin @(negedge clk); n++; end
    chk("rst_reached_write", bus.rfRegWe, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_cycle_strobes", {bus.rfRegWe, bus.rfPairWe}, 2'b00);
    @(negedge clk);
    chk("rst_mid_outputs", out_vec(), 34'h2_0000_0000);
    chk("rst_mid_rf", dut_img(), ref_img());
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_rf", dut_img(), ref_img());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmdValid = 1'b0; bus.cmdOp = 3'd0; bus.cmdAddr = 4'h0;
    bus.cmdAcc = 4'h0; bus.cmdImm = 8'h00; bus.rspReady = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 34'h2_0000_0000);
    rst = 1'b0;
    @(negedge clk);

    run_cmd(OP_FIM, 4'h2, 4'h0, 8'hA5, 0);
    preload(4'h3, 4'h7);
    run_cmd(OP_XCH, 4'h3, 4'h2, 8'h00, 0);
    preload(4'h5, 4'hF);
    run_cmd(OP_ISZ, 4'h5, 4'h0, 8'h00, 0);
    preload(4'h5, 4'h3);
    run_cmd(OP_INC, 4'h5, 4'h0, 8'h00, 0);
    preload(4'h6, 4'h1);
    preload(4'h7, 4'hC);
    run_cmd(OP_SRC, 4'h7, 4'h0, 8'h00, 0);
    preload(4'h9, 4'hB);
    run_cmd(OP_LD, 4'h9, 4'h0, 8'h00, 5);
    run_cmd(OP_NOP, 4'h4, 4'h0, 8'h00, 0);
    run_cmd(OP_RSV, 4'h1, 4'h0, 8'h00, 0);
    run_cmd(OP_FIM, 4'h9, 4'h0, 8'h3C, 0);
    run_cmd(OP_SRC, 4'h8, 4'h0, 8'h00, 0);

    preload(4'h4, 4'h9);
    reset_during_inc(4'h4);
    run_cmd(OP_LD, 4'h4, 4'h0, 8'h00, 0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) preload(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      run_cmd(op_e'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
              ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
